alu_share_ctrl: RTL and testbench
=================================

// Module: alu_share_ctrl
// PURPOSE
//  Sequencer/arbiter sharing one 32-bit ALU (8 ops, 3-bit op code, zero flag) between two requesters.
//  Round-robin grant, operand capture, op-dependent execution latency, registered response with requester ID.
//  Sits between the two issue sources and the single ALU instance.
//  Drives ALU operands/op, samples ALU result/ZF.
// PARAMETERS
//  MUL_LAT  2  cycles op 3'b010 (multiply) held in EXEC; values <1 treated as 1
//  DIV_LAT  4  cycles op 3'b011 (divide) held in EXEC; values <1 treated as 1
// PORTS
//  clk         in   1   single clock, rising edge
//  reset       in   1   synchronous, active-high
//  req0_valid  in   1   requester 0 has an op
//  req0_ready  out  1   requester 0 op accepted this cycle when valid&ready
//  req0_a      in   32  operand A
//  req0_b      in   32  operand B
//  req0_op     in   3   ALU op code
//  req1_*      ---  --  identical set for requester 1 (valid/ready/a/b/op)
//  alu_a       out  32  to ALU operand A
//  alu_b       out  32  to ALU operand B
//  alu_op      out  3   to ALU op select
//  alu_out     in   32  ALU result
//  alu_zf      in   1   ALU zero flag
//  rsp_valid   out  1   response available
//  rsp_ready   in   1   consumer takes response when valid&ready
//  rsp_id      out  1   requester that issued the op
//  rsp_data    out  32  captured ALU result
//  rsp_zf      out  1   captured zero flag
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; rr pointer = 1 (req0 wins first contention); cnt = 0.
//  - FSM IDLE -> EXEC -> RESP -> IDLE. One op in flight at a time.
//  - IDLE: reqN_ready = 1 only for granted requester; other ready = 0.
//  - Grant: sole valid requester wins. Both valid -> requester != rr pointer.
//  - Handshake (cycle T): capture a/b/op/id into regs; rr pointer <= granted id; -> EXEC.
//    cnt <= L-1, where L = MUL_LAT (010), DIV_LAT (011), 1 otherwise.
//  - alu_a/alu_b/alu_op always driven from capture regs; stable through EXEC.
//  - EXEC: cnt decrements each cycle. At cnt==0, sample alu_out/alu_zf into rsp_data/rsp_zf -> RESP.
//  - Timing: EXEC occupies T+1..T+L; rsp_valid high from T+L+1.
//  - RESP: rsp_valid=1; rsp_data/zf/id stable until rsp_ready. Both req*_ready=0.
//  - RESP handshake: rsp_valid<=0 -> IDLE. Earliest next accept is the cycle after.
//  - Back-to-back issue period: L+2 cycles.
//  - Inputs changing while not handshaking: ignored. Requester must hold valid until ready.
//  - Reset in any state: in-flight op dropped; next cycle IDLE, rsp_valid=0, pointer=1.
// CONFIGURATION
//  DIV_ZERO_TRAP_EN defined:
//   - Adds output rsp_err (1b, reset 0).
//   - Op 011 with b==0 skips EXEC: T+1 -> RESP with rsp_data=32'hFFFF_FFFF, rsp_zf=0, rsp_err=1.
//   - rsp_err=0 for all other responses.
//  Not defined: no rsp_err port; div-by-zero runs DIV_LAT cycles; ALU result returned unmodified.
// TESTING
//  1. req0 add(000) 5,7 at T, rsp_ready=1 -> rsp_valid @T+2, data=12, zf=0, id=0.
//  2. req0 & req1 valid same cycle, sub(001) 9,9 -> req0 served first (id0, data0, zf1), then req1 (id1).
//  3. Both valid continuously, and(100) -> grants alternate 0,1,0,1; issues spaced 3 cycles.
//  4. DIV_LAT=4, req1 div(011) 100,7 -> alu_op=011 held T+1..T+4, rsp_valid @T+5, data=14, id=1.
//  5. rsp_ready low 3 cycles in RESP -> rsp_* stable, both req*_ready=0; then data taken, IDLE next.
//  6. reset high during EXEC of mul -> next cycle rsp_valid=0, IDLE; with DIV_ZERO_TRAP_EN div 5/0 -> rsp_valid @T+2, data=FFFF_FFFF, err=1.

Source files
------------

// File: rtl/alu_share_ctrl_if.sv
// Bus bundle between two issue sources, the shared ALU and the response consumer.
// Latency: none (wires only); flow control is valid/ready on both request ports and the response.
// Backpressure: carried by req*_ready and rsp_ready; DIV_ZERO_TRAP_EN adds rsp_err.
interface alu_share_ctrl_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [2:0]  req0_op;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [2:0]  req1_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_out;
    logic        alu_zf;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_zf;
`ifdef DIV_ZERO_TRAP_EN
    logic        rsp_err;
`endif

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output alu_a, alu_b, alu_op,
        input  alu_out, alu_zf,
        output rsp_valid, rsp_id, rsp_data, rsp_zf,
`ifdef DIV_ZERO_TRAP_EN
        output rsp_err,
`endif
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  alu_a, alu_b, alu_op,
        output alu_out, alu_zf,
        input  rsp_valid, rsp_id, rsp_data, rsp_zf,
`ifdef DIV_ZERO_TRAP_EN
        input  rsp_err,
`endif
        output rsp_ready
    );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer sharing one ALU between two requesters; DIV_ZERO_TRAP_EN adds the rsp_err div-by-zero trap.
// Latency: accept to rsp_valid is L+1 cycles (L = MUL_LAT, DIV_LAT or 1); one op in flight, issue period L+2.
// Backpressure: req*_ready low outside IDLE; response held stable in RESP until rsp_ready.
module alu_share_ctrl #(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 4
) (
    input  logic             clk,
    input  logic             reset,
    alu_share_ctrl_if.slave  bus
);
    localparam int MUL_L = (MUL_LAT < 1) ? 1 : MUL_LAT;
    localparam int DIV_L = (DIV_LAT < 1) ? 1 : DIV_LAT;
    localparam int MAX_L = (MUL_L > DIV_L) ? MUL_L : DIV_L;
    localparam int CNT_W = (MAX_L > 1) ? $clog2(MAX_L) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        a_q, b_q, data_q;
    logic [2:0]         op_q;
    logic               id_q, rr_q, zf_q;
    logic [CNT_W-1:0]   cnt_q, cnt_init;
    logic               g0, g1, hs, ready0, ready1, trap_d;
    logic [31:0]        sel_a, sel_b;
    logic [2:0]         sel_op;
`ifdef DIV_ZERO_TRAP_EN
    logic               trap_q, err_q;
`endif

    always_comb begin
        state_d  = state_q;
        ready0   = 1'b0;
        ready1   = 1'b0;
        hs       = 1'b0;
        // rr_q holds the last winner; on contention the other requester goes
        g0       = bus.req0_valid & (~bus.req1_valid | rr_q);
        g1       = bus.req1_valid & (~bus.req0_valid | ~rr_q);
        sel_a    = g1 ? bus.req1_a  : bus.req0_a;
        sel_b    = g1 ? bus.req1_b  : bus.req0_b;
        sel_op   = g1 ? bus.req1_op : bus.req0_op;
`ifdef DIV_ZERO_TRAP_EN
        trap_d   = (sel_op == 3'b011) && (sel_b == 32'd0);
`else
        trap_d   = 1'b0;
`endif
        cnt_init = '0;
        case (sel_op)
            3'b010:  cnt_init = CNT_W'(MUL_L - 1);
            3'b011:  cnt_init = trap_d ? '0 : CNT_W'(DIV_L - 1);
            default: cnt_init = '0;
        endcase

        case (state_q)
            IDLE: begin
                ready0 = g0 & ~reset;
                ready1 = g1 & ~reset;
                hs     = (g0 | g1) & ~reset;
                if (hs) state_d = EXEC;
            end
            EXEC: begin
                if (cnt_q == '0) state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            id_q    <= 1'b0;
            rr_q    <= 1'b1;
            cnt_q   <= '0;
            data_q  <= '0;
            zf_q    <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
            trap_q  <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (hs) begin
                a_q   <= sel_a;
                b_q   <= sel_b;
                op_q  <= sel_op;
                id_q  <= g1;
                rr_q  <= g1;
                cnt_q <= cnt_init;
`ifdef DIV_ZERO_TRAP_EN
                trap_q <= trap_d;
`endif
            end
            if (state_q == EXEC) begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end else begin
`ifdef DIV_ZERO_TRAP_EN
                    data_q <= trap_q ? 32'hFFFF_FFFF : bus.alu_out;
                    zf_q   <= trap_q ? 1'b0 : bus.alu_zf;
                    err_q  <= trap_q;
`else
                    data_q <= bus.alu_out;
                    zf_q   <= bus.alu_zf;
`endif
                end
            end
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_op     = op_q;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_data   = data_q;
    assign bus.rsp_zf     = zf_q;
`ifdef DIV_ZERO_TRAP_EN
    assign bus.rsp_err    = err_q;
`endif
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed and randomized bench for alu_share_ctrl with a behavioural ALU and reference model.
// Latency and grant order are predicted from the arbitration and timing rules, not from the RTL.
// Backpressure is exercised with held loser requests and stalled rsp_ready.
module tb_alu_share_ctrl;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_share_ctrl_if bus();

    alu_share_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int passed = 0;
    int fails  = 0;
    int total  = 0;
    int cyc    = 0;
    int last_hs = 0;
    bit last_grant = 1'b1;

    always @(posedge clk) cyc++;

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a * b;
            3'd3: return (b == 32'd0) ? 32'd0 : a / b;
            3'd4: return a & b;
            3'd5: return a | b;
            3'd6: return a ^ b;
            default: return (a < b) ? 32'd1 : 32'd0;
        endcase
    endfunction

    assign bus.alu_out = alu_ref(bus.alu_a, bus.alu_b, bus.alu_op);
    assign bus.alu_zf  = (alu_ref(bus.alu_a, bus.alu_b, bus.alu_op) == 32'd0);

    function automatic bit is_trap(input logic [31:0] b, input logic [2:0] op);
`ifdef DIV_ZERO_TRAP_EN
        return (op == 3'd3) && (b == 32'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int lat_of(input logic [31:0] b, input logic [2:0] op);
        if (is_trap(b, op)) return 1;
        if (op == 3'd2) return MUL_LAT;
        if (op == 3'd3) return DIV_LAT;
        return 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        last_grant = 1'b1;
    endtask

    // One full transaction: grant, execution window, response with optional stall, return to IDLE.
    task automatic transact(input bit v0, input bit v1,
                            input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] op0,
                            input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] op1,
                            input int stall, input int gap);
        bit w;
        logic [31:0] ea, eb, ed;
        logic [2:0] eo;
        bit ezf;
        int lat, k;
        bit got;
        bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_op = op0;
        bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_op = op1;
        bus.rsp_ready  = (stall == 0);
        #1;
        w = (v0 && v1) ? ~last_grant : v1;
        chk("grant_ready0", 32'(bus.req0_ready), 32'(w == 1'b0));
        chk("grant_ready1", 32'(bus.req1_ready), 32'(w == 1'b1));
        tick();
        if (gap > 0) chk("issue_gap", 32'(cyc - last_hs), 32'(gap));
        last_hs = cyc;
        last_grant = w;
        if (w) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
        ea  = w ? a1 : a0;
        eb  = w ? b1 : b0;
        eo  = w ? op1 : op0;
        lat = lat_of(eb, eo);
        ed  = is_trap(eb, eo) ? 32'hFFFF_FFFF : alu_ref(ea, eb, eo);
        ezf = is_trap(eb, eo) ? 1'b0 : (ed == 32'd0);
        chk("alu_a", bus.alu_a, ea);
        chk("alu_b", bus.alu_b, eb);
        k = 1;
        got = 1'b0;
        while (k <= 20 && !got) begin
            if (bus.rsp_valid) begin
                got = 1'b1;
            end else begin
                chk("exec_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
                chk("exec_op", 32'(bus.alu_op), 32'(eo));
                tick();
                k++;
            end
        end
        chk("rsp_latency", 32'(k), 32'(lat + 1));
        chk("rsp_data", bus.rsp_data, ed);
        chk("rsp_zf", 32'(bus.rsp_zf), 32'(ezf));
        chk("rsp_id", 32'(bus.rsp_id), 32'(w));
`ifdef DIV_ZERO_TRAP_EN
        chk("rsp_err", 32'(bus.rsp_err), 32'(is_trap(eb, eo)));
`endif
        for (int s = 0; s < stall; s++) begin
            chk("stall_valid", 32'(bus.rsp_valid), 32'd1);
            chk("stall_data", bus.rsp_data, ed);
            chk("stall_id", 32'(bus.rsp_id), 32'(w));
            chk("stall_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
            tick();
        end
        if (stall > 0) chk("stall_end_valid", 32'(bus.rsp_valid), 32'd1);
        bus.rsp_ready = 1'b1;
        tick();
        chk("rsp_drop", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
        bus.rsp_ready  = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_alu_a", bus.alu_a, 32'd0);
        chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
        chk("rst_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);

        // add 5+7 on requester 0
        transact(1, 0, 32'd5, 32'd7, 3'd0, 32'd0, 32'd0, 3'd0, 0, 0);

        // fresh contention: req0 first, req1 still waiting then served
        do_reset();
        transact(1, 1, 32'd9, 32'd9, 3'd1, 32'd9, 32'd9, 3'd1, 0, 0);
        transact(0, 1, 32'd0, 32'd0, 3'd0, 32'd9, 32'd9, 3'd1, 0, 0);

        // continuous contention alternates grants with issue period 3
        transact(1, 1, 32'hF0F0, 32'h0FF0, 3'd4, 32'h1234, 32'hFF00, 3'd4, 0, 0);
        for (int i = 0; i < 3; i++)
            transact(1, 1, 32'hF0F0 + i, 32'h0FF0, 3'd4, 32'h1234, 32'hFF00 + i, 3'd4, 0, 3);

        // divide on requester 1, DIV_LAT cycles in EXEC
        transact(0, 1, 32'd0, 32'd0, 3'd0, 32'd100, 32'd7, 3'd3, 0, 0);

        // response stalled for three cycles
        transact(1, 0, 32'd6, 32'd7, 3'd2, 32'd0, 32'd0, 3'd0, 3, 0);

        // reset during EXEC of a multiply drops the op and restores the pointer
        bus.req0_valid = 1'b1; bus.req0_a = 32'd3; bus.req0_b = 32'd4; bus.req0_op = 3'd2;
        bus.req1_valid = 1'b0;
        #1;
        chk("mul_ready0", 32'(bus.req0_ready), 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        last_grant = 1'b1;
        chk("rstx_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rstx_alu_op", 32'(bus.alu_op), 32'd0);
        tick();
        chk("rstx_still_idle", 32'(bus.rsp_valid), 32'd0);
        transact(1, 1, 32'd11, 32'd2, 3'd6, 32'd8, 32'd1, 3'd5, 0, 0);

        // divide by zero: trapped when the trap is built in, full DIV_LAT otherwise
        transact(1, 0, 32'd5, 32'd0, 3'd3, 32'd0, 32'd0, 3'd0, 0, 0);

        for (int i = 0; i < 24; i++) begin
            int vs;
            logic [31:0] ra0, rb0, ra1, rb1;
            logic [2:0] ro0, ro1;
            vs  = $urandom_range(1, 3);
            ra0 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom);
            ra1 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom);
            rb0 = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 300));
            rb1 = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 300));
            ro0 = 3'($urandom_range(0, 7));
            ro1 = 3'($urandom_range(0, 7));
            transact(vs[0], vs[1], ra0, rb0, ro0, ra1, rb1, ro1, $urandom_range(0, 2), 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, total);
        $fatal(1);
    end
endmodule
